uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte producers.
- Accepts one byte at a time from the winning requester and drives the transmitter's enable and data inputs.
- Tracks the transmitter busy flag through launch and completion, and flags launches that the transmitter never acknowledges.
- Sits between on-chip byte sources and the UART top level (enable, inputData, txBusy).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, character width; must match the transmitter data width.
- LAUNCH_TIMEOUT, 4096, clk cycles allowed in LAUNCH for uart_busy to rise before abort.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte-available flag; held until ready.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
- uart_enable  output  1  transmit enable to the UART.
- uart_data  output  DATA_W  byte to transmit to the UART; registered.
- uart_busy  input  1  transmitter busy flag from the UART.
- grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
- active  output  1  high while any state other than IDLE.
- timeout_err  output  1  one-cycle pulse on launch abort.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; req_ready=0, uart_enable=0, uart_data=0, grant_id=0, active=0, timeout_err=0; timeout counter=0.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - If uart_busy=1, grant nothing and wait.
  - Otherwise, if any req_valid is set, select the first set bit searching from rr_ptr upward with wrap: winner w.
  - Same cycle, combinationally from registered state: req_ready[w]=1.
  - On that edge: latch uart_data<=req_data[w], grant_id<=w, rr_ptr<=(w+1) mod NUM_REQ, go to LAUNCH.
  - If no req_valid is set, stay in IDLE.
- LAUNCH:
  - uart_enable=1 (registered, asserted on the first LAUNCH cycle); counter increments every cycle.
  - When uart_busy is sampled 1: uart_enable<=0, go to WAIT_DONE.
  - When the counter reaches LAUNCH_TIMEOUT-1 with uart_busy still 0: uart_enable<=0, timeout_err pulses 1 cycle, go to IDLE.
  - The aborted byte is dropped; it is not retried and the requester has already been acked.
- WAIT_DONE:
  - uart_enable=0.
  - When uart_busy is sampled 0, go to IDLE.
  - A new grant may issue on the first IDLE cycle, giving a minimum one idle clk between bytes.
- uart_data and grant_id hold their values from grant until the next grant; they are unchanged by a timeout.
- req_valid dropping after it has been acked has no effect. Requesters must not withdraw req_valid before req_ready.
- Simultaneous requests: strict round-robin by rr_ptr. A requester that was just served has lowest priority next round.
  - Example, NUM_REQ=4: all valid gives grants 0,1,2,3,0,…
- uart_busy already high in IDLE (external transmitter use): no grant until it falls.
- Reset mid-transfer: all outputs return to reset values immediately, including uart_enable=0. The in-flight UART frame is not the arbiter's concern.
- active = (state != IDLE), registered.

Test Plan:
- Single requester: req_valid=4'b0100 with data 0xA5. Required: req_ready=4'b0100 for exactly 1 cycle; uart_data=0xA5 and grant_id=2 on the next cycle; uart_enable high until the busy model rises; active drops after busy falls.
- Contention: all four valid, data 0x10..0x13, busy model 10 cycles per byte. Required: bytes transmitted in order 0x10,0x11,0x12,0x13 with grant_id 0,1,2,3; then requester 0 re-armed with 0x20 is served next.
- Fairness: requesters 0 and 3 continuously valid. Required: grant_id alternates 0,3,0,3; no two consecutive grants go to the same index.
- Timeout: LAUNCH_TIMEOUT=16, uart_busy held 0. Required: uart_enable high for exactly 16 cycles, timeout_err pulses once, return to IDLE; the next request is granted normally.
- External busy: uart_busy=1 in IDLE while req_valid=4'b0001. Required: no req_ready until busy falls, then ready on the first cycle busy is sampled 0.
- Reset mid-LAUNCH: rst_n low asynchronously while uart_enable=1. Required: uart_enable, req_ready, active and grant_id go to 0 without waiting for a clk edge; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Launches one byte at a time and follows the transmitter busy flag to completion.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int LAUNCH_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_enable,
    output logic [DATA_W-1:0]             uart_data,
    input  logic                          uart_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q;
    logic [DATA_W-1:0]   uart_data_q;
    logic                uart_enable_q;
    logic                active_q;
    logic                timeout_err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATA_W-1:0]   lane [NUM_REQ];
    logic [NUM_REQ-1:0]  ready_vec;
    logic [ID_W-1:0]     win_idx;
    logic                win_found;
    logic [ID_W:0]       idx_ext;
    logic                grant_fire;

    // Split the packed request bus into per-requester lanes.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane[gi]      = req_data[gi*DATA_W +: DATA_W];
        assign ready_vec[gi] = grant_fire && (win_idx == ID_W'(gi));
    end

    // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_ext   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_ext >= (ID_W+1)'(NUM_REQ)) begin
                idx_ext = idx_ext - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[idx_ext[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_ext[ID_W-1:0];
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && !uart_busy && win_found;

    always_comb begin
        rr_ptr_d = win_idx + ID_W'(1);
        if (win_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end
    end

    // The accept pulse is combinational, so hold it low while reset is asserted.
    assign req_ready   = rst_n ? ready_vec : '0;
    assign uart_enable = uart_enable_q;
    assign uart_data   = uart_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            uart_data_q   <= '0;
            uart_enable_q <= 1'b0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        uart_data_q   <= lane[win_idx];
                        grant_id_q    <= win_idx;
                        rr_ptr_q      <= rr_ptr_d;
                        uart_enable_q <= 1'b1;
                        active_q      <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (uart_busy) begin
                        uart_enable_q <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Transmitter never acknowledged: drop the byte, keep data/grant_id.
                        uart_enable_q <= 1'b0;
                        timeout_err_q <= 1'b1;
                        active_q      <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    uart_enable_q <= 1'b0;
                    if (!uart_busy) begin
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    uart_enable_q <= 1'b0;
                    active_q      <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

endmodule
